chip8_memory: RTL and testbench
===============================

Name: chip8_memory

Overview:
- Unified 4 KiB CHIP-8 RAM that sits directly upstream of the CPU and serves its byte-wide fetch/data port.
- After reset it self-initialises the hex font at FONT_BASE.
- It then accepts a program image over a valid/ready byte stream into PROGRAM_BASE, and asserts `ready` to release the CPU.
- In run mode it serves CPU reads (one-cycle registered latency) and CPU writes (for FX33/FX55).

Parameters:
- ADDR_WIDTH, 12, address width; RAM depth is 2**ADDR_WIDTH bytes.
- FONT_BASE, 12'h000, address of the first font byte.
- PROGRAM_BASE, 12'h200, address of the first loaded program byte.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- cpu_address  input  12  CPU read/write byte address.
- cpu_read_data  output  8  registered read data for cpu_address.
- cpu_write_enable  input  1  CPU write strobe; honoured only in S_RUN.
- cpu_write_data  input  8  CPU write byte.
- load_valid  input  1  loader byte present.
- load_data  input  8  loader byte.
- load_ready  output  1  block accepts loader bytes.
- load_done  input  1  single-cycle pulse marking the end of the image.
- ready  output  1  init and load are complete; CPU may run.
- load_overflow  output  1  sticky flag: a loader byte arrived beyond the top of RAM.

Behaviour:
- Reset (reset=0) forces, asynchronously:
  - state=S_FONT, font index=0, load pointer=PROGRAM_BASE;
  - cpu_read_data=0, load_ready=0, ready=0, load_overflow=0.
- RAM contents are not cleared by reset.
- S_FONT:
  - On each clock k=0..79 after reset release, write font[k] to FONT_BASE+k.
  - On the edge performing the 80th write, go to S_LOAD and set load_ready=1. load_ready is therefore first high 80 edges after release.
  - Loader and CPU writes are ignored in this state.
- S_LOAD:
  - load_ready=1. A byte transfers on any edge with load_valid & load_ready.
  - For each transferred byte: write to the load pointer, then increment the pointer.
  - When the pointer is at 12'hFFF, write the byte and set a saturated flag; the pointer never wraps.
  - Transfers while saturated: byte dropped, load_overflow<=1 (sticky until reset), load_ready stays 1 so the source can drain.
  - load_done exits to S_RUN: load_ready<=0 and ready<=1 on the same edge.
  - If load_valid and load_done are both high on one edge, the byte is written first, then the block exits.
  - load_done with zero bytes loaded is legal.
  - CPU writes are ignored in this state.
- S_RUN (terminal until reset):
  - ready=1, load_ready=0; loader inputs are ignored.
  - cpu_write_enable=1 writes cpu_write_data to mem[cpu_address] on that edge.
- Read port, all states: every edge, cpu_read_data <= mem[cpu_address], giving one-cycle latency.
  - Read-during-write to the same address returns the old data.
- RAM has a single write port. Write sources are mutually exclusive by state: font index in S_FONT, loader in S_LOAD, CPU in S_RUN.
- Width rules:
  - Font index is 7-bit and compares against 79.
  - Load pointer is ADDR_WIDTH bits plus the saturated flag.
  - All address arithmetic is unsigned with no wrap.
- Reset asserted mid-load: the block returns to S_FONT and replays the font. Previously loaded program bytes remain in RAM until overwritten by the next load.

Decomposition:
- Shared include chip8_defs.vh: RAM_DEPTH, FONT_BYTES=80, FONT_BASE, PROGRAM_BASE, and the state encodings S_FONT=2'd0, S_LOAD=2'd1, S_RUN=2'd2.
- Sub-module chip8_font_rom: combinational 7-bit index -> 8-bit byte table of the standard 0..F glyphs, 5 bytes each. The "0" glyph is F0 90 90 90 F0; the "F" glyph is F0 80 F0 80 80.

Test Plan:
1. Font init: release reset -> load_ready rises exactly on edge 80, ready=0. Reads return 0x000->0xF0, 0x001->0x90, 0x04B->0xF0, 0x04F->0x80.
2. Program load: stream 00,E0,A2,2A with load_valid toggling 1,0,1,1,0,1, then load_done -> ready=1 and load_ready=0 on the load_done edge. Reads return 0x200..0x203 = 00,E0,A2,2A and load_overflow=0.
3. Overflow: stream 3585 bytes (byte i = i[7:0]), then load_done -> 0xFFF holds 0xFF (byte 3583) and load_overflow=1. 0x200 still holds 0x00; 0x000 still holds 0xF0.
4. CPU write: in S_LOAD, cpu_write_enable with addr 0x300, data 0x5A -> ignored. In S_RUN, the same write -> read of 0x300 returns 0x5A one cycle after the address is presented. A same-cycle read of 0x300 during the write returns the old value.
5. Simultaneous: load_valid=1 with data 0x12 and load_done=1 on the same edge, as the first byte -> 0x200=0x12 and ready=1 on that edge.
6. Reset mid-load: after 10 bytes loaded, pulse reset low asynchronously between edges -> all outputs go to 0 immediately. The font replays (load_ready again on edge 80), and 0x200..0x209 retain the earlier bytes.

Source files
------------

// File: rtl/chip8_memory_pkg.sv
// Shared definitions for the CHIP-8 unified RAM block.
//   - default geometry (address width, font and program base addresses)
//   - font table size and last font index
//   - controller state encoding
package chip8_memory_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 12;
   localparam logic [11:0] DEF_FONT_BASE    = 12'h000;
   localparam logic [11:0] DEF_PROGRAM_BASE = 12'h200;

   localparam int unsigned FONT_BYTES = 80;
   localparam logic [6:0]  FONT_LAST  = 7'd79;

   typedef enum logic [1:0] {
      S_FONT = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/chip8_memory_font_rom.sv
// Combinational hex font table: sixteen 5-byte glyphs (0..F), 80 bytes total.
// Ports:
//   font_idx  in   7  byte index 0..79 (larger indices return 0)
//   font_data out  8  glyph byte
module chip8_memory_font_rom
   import chip8_memory_pkg::*;
(
   input  logic [6:0] font_idx,
   output logic [7:0] font_data
);

   // Byte 0 sits in the most significant position of the table.
   localparam logic [8*FONT_BYTES-1:0] GLYPHS = {
      40'hF0_90_90_90_F0,   // 0
      40'h20_60_20_20_70,   // 1
      40'hF0_10_F0_80_F0,   // 2
      40'hF0_10_F0_10_F0,   // 3
      40'h90_90_F0_10_10,   // 4
      40'hF0_80_F0_10_F0,   // 5
      40'hF0_80_F0_90_F0,   // 6
      40'hF0_10_20_40_40,   // 7
      40'hF0_90_F0_90_F0,   // 8
      40'hF0_90_F0_10_F0,   // 9
      40'hF0_90_F0_90_90,   // A
      40'hE0_90_E0_90_E0,   // B
      40'hF0_80_80_80_F0,   // C
      40'hE0_90_90_90_E0,   // D
      40'hF0_80_F0_80_F0,   // E
      40'hF0_80_F0_80_80    // F
   };

   logic [6:0] rev_idx;
   logic [9:0] bit_pos;

   always_comb begin
      rev_idx   = FONT_LAST - font_idx;
      bit_pos   = {rev_idx, 3'b000};
      font_data = 8'h00;
      if (font_idx <= FONT_LAST) begin
         font_data = GLYPHS[bit_pos +: 8];
      end
   end

endmodule

// File: rtl/chip8_memory.sv
// Unified CHIP-8 RAM: self-loads the hex font after reset, accepts a program
// image over a valid/ready byte stream, then serves CPU reads and writes.
//
// state  | meaning
// S_FONT | writing font byte font_idx to FONT_BASE+font_idx, one per clock
// S_LOAD | accepting loader bytes at load_ptr until load_done
// S_RUN  | CPU owns the write port; terminal until reset
//
// Ports:
//   clk, reset (async, active low)
//   cpu_address/cpu_read_data     registered read port, one-cycle latency
//   cpu_write_enable/_data        CPU write, honoured only in S_RUN
//   load_valid/load_data/load_ready/load_done  program loader stream
//   ready          init and load complete
//   load_overflow  sticky: loader byte arrived beyond the top of RAM
module chip8_memory
   import chip8_memory_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] FONT_BASE    = ADDR_WIDTH'(DEF_FONT_BASE),
   parameter logic [ADDR_WIDTH-1:0] PROGRAM_BASE = ADDR_WIDTH'(DEF_PROGRAM_BASE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   output logic [7:0]            cpu_read_data,
   input  logic                  cpu_write_enable,
   input  logic [7:0]            cpu_write_data,
   input  logic                  load_valid,
   input  logic [7:0]            load_data,
   output logic                  load_ready,
   input  logic                  load_done,
   output logic                  ready,
   output logic                  load_overflow
);

   localparam int unsigned RAM_DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   state_t                state;
   logic [6:0]            font_idx;
   logic [7:0]            font_data;
   logic [ADDR_WIDTH-1:0] load_ptr;
   logic                  load_sat;
   logic                  load_fire;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]            wr_data;

   logic [7:0]            mem [RAM_DEPTH];

   chip8_memory_font_rom u_font_rom (
      .font_idx  (font_idx),
      .font_data (font_data)
   );

   // load_ready is only ever high in S_LOAD.
   assign load_fire = load_valid & load_ready;

   // Single write port; the owner is selected purely by state.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cpu_address;
      wr_data = cpu_write_data;
      case (state)
         S_FONT: begin
            wr_en   = 1'b1;
            wr_addr = FONT_BASE + ADDR_WIDTH'(font_idx);
            wr_data = font_data;
         end
         S_LOAD: begin
            wr_en   = load_fire & ~load_sat;
            wr_addr = load_ptr;
            wr_data = load_data;
         end
         S_RUN: begin
            wr_en   = cpu_write_enable;
         end
         default: ;
      endcase
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-before-write: a same-address write shows up one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_read_data <= 8'h00;
      end else begin
         cpu_read_data <= mem[cpu_address];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_FONT;
         font_idx      <= 7'd0;
         load_ptr      <= PROGRAM_BASE;
         load_sat      <= 1'b0;
         load_ready    <= 1'b0;
         ready         <= 1'b0;
         load_overflow <= 1'b0;
      end else begin
         case (state)
            S_FONT: begin
               if (font_idx == FONT_LAST) begin
                  state      <= S_LOAD;
                  load_ready <= 1'b1;
               end else begin
                  font_idx   <= font_idx + 7'd1;
               end
            end
            S_LOAD: begin
               if (load_fire) begin
                  if (load_sat) begin
                     load_overflow <= 1'b1;
                  end else if (load_ptr == ADDR_MAX) begin
                     // Top byte is written; pointer holds rather than wrapping.
                     load_sat <= 1'b1;
                  end else begin
                     load_ptr <= load_ptr + 1'b1;
                  end
               end
               if (load_done) begin
                  state      <= S_RUN;
                  load_ready <= 1'b0;
                  ready      <= 1'b1;
               end
            end
            S_RUN: begin
               load_ready <= 1'b0;
               ready      <= 1'b1;
            end
            default: begin
               state <= S_FONT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_memory.sv
module tb_chip8_memory;

   logic        clk;
   logic        reset;
   logic [11:0] cpu_address;
   logic [7:0]  cpu_read_data;
   logic        cpu_write_enable;
   logic [7:0]  cpu_write_data;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        load_done;
   logic        ready;
   logic        load_overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q [$];
   string      tag_q [$];

   chip8_memory dut (
      .clk              (clk),
      .reset            (reset),
      .cpu_address      (cpu_address),
      .cpu_read_data    (cpu_read_data),
      .cpu_write_enable (cpu_write_enable),
      .cpu_write_data   (cpu_write_data),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_ready       (load_ready),
      .load_done        (load_done),
      .ready            (ready),
      .load_overflow    (load_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an address, queue the expected byte, compare after the next edge.
   task automatic rd(input logic [11:0] a, input logic [7:0] e);
      cpu_address = a;
      exp_q.push_back(e);
      tag_q.push_back($sformatf("rd_%03h", a));
      tick();
      chk(tag_q.pop_front(), {8'h00, cpu_read_data}, {8'h00, exp_q.pop_front()});
   endtask

   // Assert reset between edges, check outputs, release, count edges to load_ready.
   task automatic do_reset(input string tag);
      int cnt;
      load_valid       = 1'b0;
      load_done        = 1'b0;
      cpu_write_enable = 1'b0;
      reset = 1'b0;
      #2;
      chk({tag, "_rst_rdata"}, {8'h00, cpu_read_data}, 16'h0);
      chk({tag, "_rst_lready"}, {15'h0, load_ready}, 16'h0);
      chk({tag, "_rst_ready"}, {15'h0, ready}, 16'h0);
      chk({tag, "_rst_ovf"}, {15'h0, load_overflow}, 16'h0);
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      while (cnt < 200 && load_ready !== 1'b1) begin
         tick();
         cnt++;
      end
      chk({tag, "_font_edges"}, 16'(cnt), 16'd80);
      chk({tag, "_font_ready"}, {15'h0, ready}, 16'h0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      load_valid = 1'b1;
      load_data  = b;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic finish_load(input string tag);
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      chk({tag, "_done_ready"}, {15'h0, ready}, 16'h1);
      chk({tag, "_done_lready"}, {15'h0, load_ready}, 16'h0);
   endtask

   initial begin
      logic       vpat [6];
      logic [7:0] prog [4];
      int         k;

      reset            = 1'b0;
      cpu_address      = 12'h000;
      cpu_write_enable = 1'b0;
      cpu_write_data   = 8'h00;
      load_valid       = 1'b0;
      load_data        = 8'h00;
      load_done        = 1'b0;
      tick();

      // Font init
      do_reset("a");
      rd(12'h000, 8'hF0);
      rd(12'h001, 8'h90);
      rd(12'h04B, 8'hF0);
      rd(12'h04F, 8'h80);
      rd(12'h005, 8'h20);
      rd(12'h037, 8'hE0);

      // Program load with gaps in load_valid
      vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      prog = '{8'h00, 8'hE0, 8'hA2, 8'h2A};
      k = 0;
      for (int c = 0; c < 6; c++) begin
         load_valid = vpat[c];
         load_data  = vpat[c] ? prog[k] : 8'h55;
         tick();
         if (vpat[c]) k++;
      end
      load_valid = 1'b0;
      chk("a_pre_done_ready", {15'h0, ready}, 16'h0);
      finish_load("a");
      for (int i = 0; i < 4; i++) rd(12'h200 + 12'(i), prog[i]);
      chk("a_ovf", {15'h0, load_overflow}, 16'h0);

      // Overflow: 3585 bytes fill 0x200..0xFFF and one more is dropped
      do_reset("b");
      load_valid = 1'b1;
      for (int i = 0; i < 3585; i++) begin
         load_data = 8'(i);
         tick();
      end
      load_valid = 1'b0;
      chk("b_ovf_flag", {15'h0, load_overflow}, 16'h1);
      chk("b_ovf_lready", {15'h0, load_ready}, 16'h1);
      // CPU write in S_LOAD must be ignored
      cpu_address      = 12'h300;
      cpu_write_data   = 8'h5A;
      cpu_write_enable = 1'b1;
      tick();
      cpu_write_enable = 1'b0;
      finish_load("b");
      chk("b_ovf_after", {15'h0, load_overflow}, 16'h1);
      rd(12'hFFF, 8'hFF);
      rd(12'hFFE, 8'hFE);
      rd(12'h200, 8'h00);
      rd(12'h2FF, 8'hFF);
      rd(12'h000, 8'hF0);
      rd(12'h300, 8'h00);

      // CPU write in S_RUN with same-cycle read of old data
      cpu_address      = 12'h300;
      cpu_write_data   = 8'h5A;
      cpu_write_enable = 1'b1;
      exp_q.push_back(8'h00);
      tag_q.push_back("b_rdw_old");
      tick();
      cpu_write_enable = 1'b0;
      chk(tag_q.pop_front(), {8'h00, cpu_read_data}, {8'h00, exp_q.pop_front()});
      rd(12'h300, 8'h5A);
      send_byte(8'h77);
      chk("b_run_lready", {15'h0, load_ready}, 16'h0);
      chk("b_run_ready", {15'h0, ready}, 16'h1);

      // Simultaneous first byte and load_done
      do_reset("c");
      load_valid = 1'b1;
      load_data  = 8'h12;
      load_done  = 1'b1;
      tick();
      load_valid = 1'b0;
      load_done  = 1'b0;
      chk("c_ready", {15'h0, ready}, 16'h1);
      chk("c_lready", {15'h0, load_ready}, 16'h0);
      rd(12'h200, 8'h12);
      rd(12'h201, 8'h01);

      // Reset mid-load keeps previously loaded bytes
      do_reset("d");
      cpu_address = 12'h000;
      for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
      chk("d_pre_rdata", {8'h00, cpu_read_data}, 16'h00F0);
      chk("d_pre_lready", {15'h0, load_ready}, 16'h1);
      do_reset("d2");
      for (int i = 0; i < 10; i++) rd(12'h200 + 12'(i), 8'hA0 + 8'(i));
      rd(12'h00A, 8'hF0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
